spi_cmd_sequencer: RTL and testbench
====================================

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter XFER_CYCLES, default 18, mclk cycles start is held high per transfer.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, mclk cycles start is held low between transfers (>=3).
REQ-004 SHALL have port mclk  in  1  clock.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  host command offered.
REQ-007 SHALL have port cmd_ready  out  1  FIFO can accept a command.
REQ-008 SHALL have port cmd_rd_wr  in  1  1=read, 0=write.
REQ-009 SHALL have port cmd_addr  in  7  target register address.
REQ-010 SHALL have port cmd_wdata  in  8  write data, ignored for reads.
REQ-011 SHALL have port rsp_valid  out  1  read response available.
REQ-012 SHALL have port rsp_ready  in  1  host accepts response.
REQ-013 SHALL have port rsp_addr  out  7  address of the completed read.
REQ-014 SHALL have port rsp_rdata  out  8  read data.
REQ-015 SHALL have port start  out  1  to SPI master start.
REQ-016 SHALL have port master_rd_wr  out  1  to SPI master.
REQ-017 SHALL have port master_address  out  7  to SPI master.
REQ-018 SHALL have port master_out_data  out  8  to SPI master, write payload.
REQ-019 SHALL have port master_in_data  in  8  from SPI master, read result (updates on cs rising).
REQ-020 SHALL have port busy  out  1  high outside IDLE or FIFO non-empty.

Function
REQ-021 Command push SHALL occur when cmd_valid && cmd_ready at posedge mclk; cmd_ready = FIFO not full.
REQ-022 FSM states SHALL be IDLE, LOAD, XFER, GAP, RESP.
REQ-023 IDLE -> LOAD when FIFO non-empty; LOAD pops head into master_rd_wr/master_address/master_out_data registers (held stable until next LOAD).
REQ-024 LOAD -> XFER after 1 cycle; start SHALL be 1 for exactly XFER_CYCLES consecutive cycles in XFER, driven from a register.
REQ-025 XFER -> GAP with start=0; GAP SHALL last GAP_CYCLES cycles to let cs rise and master_in_data settle.
REQ-026 At GAP end: write command -> IDLE (no response); read command -> RESP with rsp_rdata=master_in_data, rsp_addr=master_address, rsp_valid=1.
REQ-027 RESP SHALL hold rsp_valid/rsp_addr/rsp_rdata stable until rsp_ready; on rsp_valid && rsp_ready -> IDLE, rsp_valid=0 next cycle.
REQ-028 Back-to-back commands SHALL produce start low for no fewer than GAP_CYCLES+1 cycles between transfers (GAP + LOAD).
REQ-029 Push into full FIFO SHALL be ignored (cmd_ready=0); simultaneous push and pop when full SHALL be refused, no corruption.
REQ-030 Simultaneous push and pop when non-full SHALL keep occupancy constant; pointers wrap modulo FIFO_DEPTH.
REQ-031 FIFO SHALL accept pushes during XFER/GAP/RESP; order of issue SHALL equal order of push.
REQ-032 Reset SHALL abort any transfer mid-operation: start=0 immediately on the next edge, FIFO flushed, pending response dropped.

Reset
REQ-033 On reset low at posedge mclk: state=IDLE, start=0, master_rd_wr=0, master_address=0, master_out_data=0, rsp_valid=0, rsp_addr=0, rsp_rdata=0, FIFO empty, cmd_ready=1, busy=0.
REQ-034 Counters (transfer, gap) SHALL clear to 0 on reset.

Structure
REQ-035 Shared package spi_pkg SHALL hold the FSM state enum, the command struct {rd_wr, addr[6:0], wdata[7:0]} and default XFER_CYCLES/GAP_CYCLES constants.
REQ-036 Command FIFO SHALL be a sub-module spi_cmd_fifo (parameter DEPTH, push/pop/full/empty, synchronous, active-low reset).
REQ-037 Top-level SHALL be instantiable alongside top_dut with start/master_* ports wired one-to-one.

Verification
REQ-038 Single write {0,0x15,0xA5}: start high 18 cycles, master_address=0x15, master_out_data=0xA5, no rsp_valid, busy drops after GAP.
REQ-039 Single read addr 0x2A, slave_out_data=0x3C: rsp_valid with rsp_addr=0x2A, rsp_rdata=0x3C.
REQ-040 Push 5 commands with no pops: 5th refused (cmd_ready=0), first 4 issued in order, start gap >=5 cycles.
REQ-041 Read with rsp_ready held 0 for 10 cycles: rsp fields stable, next FIFO command not issued until handshake.
REQ-042 Assert reset at cycle 9 of XFER: start=0 next cycle, FIFO empty, rsp_valid=0, cmd_ready=1.
REQ-043 Alternating write 0x11->0x05 then read 0x05 through the slave model: rsp_rdata=0x11 when slave echoes stored data.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI command sequencer.
package spi_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_XFER = 3'd2,
    ST_GAP  = 3'd3,
    ST_RESP = 3'd4
  } spi_state_t;

  // One queued host command
  typedef struct packed {
    logic       rd_wr;
    logic [6:0] addr;
    logic [7:0] wdata;
  } spi_cmd_t;

  // Default timing of one SPI transfer, in mclk cycles
  localparam int XFER_CYCLES_DEF = 18;
  localparam int GAP_CYCLES_DEF  = 4;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Small synchronous command FIFO. Pushes into a full FIFO and pops from an
// empty FIFO are ignored; the head entry is readable combinationally.
module spi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Storage write; contents need no reset because occupancy guards reads
  always_ff @(posedge mclk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge mclk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues host register commands and plays them one at a time into an SPI
// master: holds start high for a fixed transfer window, waits a gap for cs
// to rise, then returns read data through a valid/ready response port.
module spi_cmd_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int XFER_CYCLES = XFER_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd_wr,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [6:0] rsp_addr,
  output logic [7:0] rsp_rdata,
  output logic       start,
  output logic       master_rd_wr,
  output logic [6:0] master_address,
  output logic [7:0] master_out_data,
  input  logic [7:0] master_in_data,
  output logic       busy
);

  localparam int XW = $clog2(XFER_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [XW-1:0] XFER_LAST = XW'(XFER_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  spi_state_t       state_q, state_d;
  logic [XW-1:0]    xfer_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic             start_q;
  logic             rd_wr_q;
  logic [6:0]       addr_q;
  logic [7:0]       wdata_q;
  logic             rsp_valid_q;
  logic [6:0]       rsp_addr_q;
  logic [7:0]       rsp_rdata_q;

  spi_cmd_t         push_cmd;
  spi_cmd_t         head_cmd;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign push_cmd = '{rd_wr: cmd_rd_wr, addr: cmd_addr, wdata: cmd_wdata};

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(spi_cmd_t))
  ) u_fifo (
    .mclk      (mclk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state logic; the FIFO head is consumed in the single LOAD cycle
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        fifo_pop = 1'b1;
        state_d  = ST_XFER;
      end
      ST_XFER: if (xfer_cnt_q == XFER_LAST) state_d = ST_GAP;
      ST_GAP:  if (gap_cnt_q == GAP_LAST) state_d = rd_wr_q ? ST_RESP : ST_IDLE;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, registered start, master command and response registers
  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      xfer_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      start_q     <= 1'b0;
      rd_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      // start is high exactly while the registered state is XFER
      start_q    <= (state_d == ST_XFER);
      xfer_cnt_q <= (state_q == ST_XFER) ? xfer_cnt_q + 1'b1 : '0;
      gap_cnt_q  <= (state_q == ST_GAP)  ? gap_cnt_q + 1'b1  : '0;
      if (state_q == ST_LOAD) begin
        rd_wr_q <= head_cmd.rd_wr;
        addr_q  <= head_cmd.addr;
        wdata_q <= head_cmd.wdata;
      end
      if (state_q == ST_GAP && state_d == ST_RESP) begin
        rsp_valid_q <= 1'b1;
        rsp_addr_q  <= addr_q;
        rsp_rdata_q <= master_in_data;
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign cmd_ready       = !fifo_full;
  assign start           = start_q;
  assign master_rd_wr    = rd_wr_q;
  assign master_address  = addr_q;
  assign master_out_data = wdata_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_addr        = rsp_addr_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign busy            = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed plus randomized bench for spi_cmd_sequencer with an SPI slave
// register-file model and a command-order reference model.
module tb_spi_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int XC    = 18;
  localparam int GC    = 4;

  typedef struct {
    bit       rd;
    bit [6:0] addr;
    bit [7:0] wd;
  } tcmd_t;

  typedef struct {
    bit       rd;
    bit [6:0] addr;
    bit [7:0] wd;
    int       hi_len;
    int       lo_len;
  } txfer_t;

  typedef struct {
    bit [6:0] addr;
    bit [7:0] data;
  } trsp_t;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rd_wr = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       start;
  logic       master_rd_wr;
  logic [6:0] master_address;
  logic [7:0] master_out_data;
  logic [7:0] master_in_data = '0;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] slave_mem [128];
  logic [7:0] ref_mem   [128];
  tcmd_t      exp_q [$];
  trsp_t      exp_rsp_q [$];
  txfer_t     obs_q [$];
  trsp_t      rsp_obs_q [$];

  spi_cmd_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .XFER_CYCLES (XC),
    .GAP_CYCLES  (GC)
  ) dut (
    .mclk            (mclk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_rd_wr       (cmd_rd_wr),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_addr        (rsp_addr),
    .rsp_rdata       (rsp_rdata),
    .start           (start),
    .master_rd_wr    (master_rd_wr),
    .master_address  (master_address),
    .master_out_data (master_out_data),
    .master_in_data  (master_in_data),
    .busy            (busy)
  );

  always #5 mclk = ~mclk;

  // Transfer monitor and SPI slave: records each completed start pulse and
  // applies it to the slave register file when cs rises.
  int     hi_cnt = 0;
  int     lo_cnt = 1000;
  logic   start_prev = 1'b0;
  txfer_t cur;
  always @(negedge mclk) begin
    if (!reset) begin
      hi_cnt     = 0;
      lo_cnt     = 1000;
      start_prev = 1'b0;
    end else begin
      if (start && !start_prev) begin
        cur.rd     = master_rd_wr;
        cur.addr   = master_address;
        cur.wd     = master_out_data;
        cur.lo_len = lo_cnt;
        hi_cnt     = 1;
      end else if (start) begin
        hi_cnt++;
      end else if (start_prev) begin
        cur.hi_len = hi_cnt;
        obs_q.push_back(cur);
        if (cur.rd) master_in_data = slave_mem[cur.addr];
        else        slave_mem[cur.addr] = cur.wd;
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      start_prev = start;
    end
  end

  // Response monitor: one entry per completed valid/ready handshake
  always @(negedge mclk) begin
    if (reset && rsp_valid && rsp_ready) rsp_obs_q.push_back('{rsp_addr, rsp_rdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic push_cmd(input bit rd, input bit [6:0] a, input bit [7:0] d, output bit acc);
    cmd_rd_wr = rd;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    acc = cmd_ready;
    if (acc) exp_q.push_back('{rd, a, d});
    step(1);
    cmd_valid = 1'b0;
  endtask

  // Compare the next observed transfer with the next command in push order
  task automatic check_next_xfer(input string tag);
    txfer_t o;
    tcmd_t  e;
    int     n = 0;
    while (obs_q.size() == 0 && n < 3000) begin
      step(1);
      n++;
    end
    chk({tag, "_seen"}, 32'(obs_q.size() > 0), 1);
    chk({tag, "_expected"}, 32'(exp_q.size() > 0), 1);
    if (obs_q.size() == 0 || exp_q.size() == 0) return;
    o = obs_q.pop_front();
    e = exp_q.pop_front();
    $display("xfer %s rd=%0d addr=%02h wd=%02h hi=%0d lo=%0d", tag, o.rd, o.addr, o.wd, o.hi_len, o.lo_len);
    chk({tag, "_rd"}, o.rd, e.rd);
    chk({tag, "_addr"}, o.addr, e.addr);
    if (!e.rd) chk({tag, "_wdata"}, o.wd, e.wd);
    chk({tag, "_hi_len"}, o.hi_len, XC);
    chk({tag, "_lo_len_ok"}, 32'(o.lo_len >= GC + 1), 1);
    if (e.rd) exp_rsp_q.push_back('{e.addr, ref_mem[e.addr]});
    else      ref_mem[e.addr] = e.wd;
  endtask

  task automatic check_rsp(input string tag);
    trsp_t o;
    trsp_t e;
    int    n = 0;
    while (rsp_obs_q.size() == 0 && n < 3000) begin
      step(1);
      n++;
    end
    chk({tag, "_rsp_seen"}, 32'(rsp_obs_q.size() > 0), 1);
    chk({tag, "_rsp_expected"}, 32'(exp_rsp_q.size() > 0), 1);
    if (rsp_obs_q.size() == 0 || exp_rsp_q.size() == 0) return;
    o = rsp_obs_q.pop_front();
    e = exp_rsp_q.pop_front();
    $display("rsp %s addr=%02h data=%02h", tag, o.addr, o.data);
    chk({tag, "_rsp_addr"}, o.addr, e.addr);
    chk({tag, "_rsp_data"}, o.data, e.data);
  endtask

  initial begin
    bit         acc;
    int         n;
    int         nrand;
    logic [6:0] held_addr;
    logic [7:0] held_data;

    for (int i = 0; i < 128; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end

    // Reset state
    step(3);
    chk("rst_start", start, 0);
    chk("rst_master_rd_wr", master_rd_wr, 0);
    chk("rst_master_address", master_address, 0);
    chk("rst_master_out_data", master_out_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    step(2);

    // Single write
    push_cmd(1'b0, 7'h15, 8'hA5, acc);
    chk("wr_accept", acc, 1);
    check_next_xfer("wr15");
    n = 0;
    while (busy && n < 50) begin
      step(1);
      n++;
    end
    chk("wr_busy_drops", busy, 0);
    chk("wr_no_rsp", 32'(rsp_obs_q.size()), 0);
    chk("wr_rsp_valid", rsp_valid, 0);

    // Single read with known slave contents
    slave_mem[7'h2A] = 8'h3C;
    ref_mem[7'h2A]   = 8'h3C;
    push_cmd(1'b1, 7'h2A, 8'h00, acc);
    check_next_xfer("rd2a");
    check_rsp("rd2a");

    // Read response held off while the FIFO fills up
    rsp_ready = 1'b0;
    push_cmd(1'b1, 7'h40, 8'h00, acc);
    check_next_xfer("rd40");
    n = 0;
    while (!rsp_valid && n < 50) begin
      step(1);
      n++;
    end
    chk("hold_rsp_valid", rsp_valid, 1);
    chk("hold_rsp_addr", rsp_addr, 7'h40);
    held_addr = rsp_addr;
    held_data = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b0, 7'(7'h50 + i), 8'($urandom), acc);
      chk($sformatf("full_push%0d", i), acc, (i < DEPTH) ? 1 : 0);
    end
    chk("full_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_addr", rsp_addr, held_addr);
      chk("hold_data", rsp_rdata, held_data);
      chk("hold_no_start", start, 0);
      step(1);
    end
    chk("hold_no_xfer", 32'(obs_q.size()), 0);
    rsp_ready = 1'b1;
    step(1);
    chk("rsp_valid_clears", rsp_valid, 0);
    check_rsp("rd40");
    for (int i = 0; i < DEPTH; i++) check_next_xfer($sformatf("fill%0d", i));

    // Write then read back through the slave
    push_cmd(1'b0, 7'h05, 8'h11, acc);
    push_cmd(1'b1, 7'h05, 8'h00, acc);
    check_next_xfer("wr05");
    check_next_xfer("rd05");
    chk("echo_model", exp_rsp_q.size() > 0 ? exp_rsp_q[0].data : 8'h00, 8'h11);
    check_rsp("rd05");

    // Reset in the middle of a transfer with another command queued
    push_cmd(1'b0, 7'h33, 8'h77, acc);
    push_cmd(1'b1, 7'h34, 8'h00, acc);
    n = 0;
    while (!start && n < 50) begin
      step(1);
      n++;
    end
    chk("abort_start_seen", start, 1);
    step(8);
    reset = 1'b0;
    step(1);
    chk("abort_start", start, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    reset = 1'b1;
    step(40);
    chk("abort_no_xfer", 32'(obs_q.size()), 0);
    chk("abort_idle", busy, 0);

    // Randomized command stream
    nrand = 24;
    for (int k = 0; k < nrand; k++) begin
      step($urandom_range(0, 25));
      n = 0;
      while (!cmd_ready && n < 500) begin
        step(1);
        n++;
      end
      chk("rand_ready_seen", cmd_ready, 1);
      push_cmd(1'($urandom), 7'($urandom), 8'($urandom), acc);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) check_next_xfer($sformatf("rand%0d", k));
    n = exp_rsp_q.size();
    for (int k = 0; k < n; k++) check_rsp($sformatf("rand%0d", k));
    step(40);
    chk("end_idle", busy, 0);
    chk("end_no_extra_xfer", 32'(obs_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
